// File: rtl/key_event_gen.sv
// key_event_gen: turns held PS/2 key levels into discrete game events.
// Detects presses, up-release and left/right auto-repeat, buffers each event
// class in a pending flag, and pushes the lowest pending code into a small
// FIFO drained through a valid/ready handshake.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   up/left/right/enter  held key levels, synchronous to clk
//   evt_valid         FIFO head holds an event
//   evt_code[2:0]     event code at the FIFO head
//   evt_ready         consumer accepts the head this cycle
//   held[3:0]         registered key levels {enter,right,left,up}
//   overflow          sticky: a pending event was merged (lost)
//   ovf_clr           synchronous clear of overflow
module key_event_gen #(
    parameter int unsigned DELAY_CYC  = 25000000,
    parameter int unsigned RATE_CYC   = 5000000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       up,
    input  logic       left,
    input  logic       right,
    input  logic       enter,
    output logic       evt_valid,
    output logic [2:0] evt_code,
    input  logic       evt_ready,
    output logic [3:0] held,
    output logic       overflow,
    input  logic       ovf_clr
);

    localparam int unsigned MAX_CYC = (DELAY_CYC > RATE_CYC) ? DELAY_CYC : RATE_CYC;
    localparam int unsigned CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int unsigned AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNTW    = AW + 1;
    localparam int unsigned NCODE   = 7;

    localparam logic [CW-1:0]   DELAY_LAST = CW'(DELAY_CYC - 1);
    localparam logic [CW-1:0]   RATE_LAST  = CW'(RATE_CYC - 1);
    localparam logic [CNTW-1:0] FULL_CNT   = CNTW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    // index 0 = left, 1 = right
    rpt_state_t      rpt_state_q [2];
    rpt_state_t      rpt_state_d [2];
    logic [CW-1:0]   cnt_q [2];
    logic [CW-1:0]   cnt_d [2];
    logic [1:0]      rpt_tick;
    logic [1:0]      dir_key;
    logic [1:0]      dir_press;

    logic [NCODE-1:0] pend_q;
    logic [NCODE-1:0] pend_d;
    logic [NCODE-1:0] evt_set;
    logic [NCODE-1:0] grant;
    logic             merge;
    logic             overflow_d;

    logic [2:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_d;
    logic [CNTW-1:0]  count;
    logic [CNTW-1:0]  count_d;
    logic [CNTW-1:0]  after_pop;
    logic             pop;
    logic             push;
    logic             can_push;
    logic [2:0]       push_code;
    logic [2:0]       head_d;

    assign dir_key   = {right, left};
    assign dir_press = {right & ~held[2], left & ~held[1]};

    // Repeat FSMs: next state, counters and repeat ticks
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rpt_state_d[i] = rpt_state_q[i];
            cnt_d[i]       = cnt_q[i];
            rpt_tick[i]    = 1'b0;
            if (!dir_key[i]) begin
                // release wins over a same-cycle tick
                rpt_state_d[i] = RPT_IDLE;
                cnt_d[i]       = '0;
            end else begin
                case (rpt_state_q[i])
                    RPT_IDLE: begin
                        if (dir_press[i]) begin
                            rpt_state_d[i] = RPT_DELAY;
                            cnt_d[i]       = '0;
                        end
                    end
                    RPT_DELAY: begin
                        if (cnt_q[i] == DELAY_LAST) begin
                            rpt_tick[i]    = 1'b1;
                            cnt_d[i]       = '0;
                            rpt_state_d[i] = RPT_REPEAT;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CW'(1);
                        end
                    end
                    RPT_REPEAT: begin
                        if (cnt_q[i] == RATE_LAST) begin
                            rpt_tick[i] = 1'b1;
                            cnt_d[i]    = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CW'(1);
                        end
                    end
                    default: begin
                        rpt_state_d[i] = RPT_IDLE;
                        cnt_d[i]       = '0;
                    end
                endcase
            end
        end
    end

    // Event detection, indexed by event code
    always_comb begin
        evt_set    = '0;
        evt_set[0] = up & ~held[0];
        evt_set[1] = left & ~held[1];
        evt_set[2] = right & ~held[2];
        evt_set[3] = enter & ~held[3];
        evt_set[4] = rpt_tick[0];
        evt_set[5] = rpt_tick[1];
        evt_set[6] = ~up & held[0];
    end

    assign pop      = evt_valid & evt_ready;
    assign can_push = (count != FULL_CNT) | pop;

    // Priority arbiter: lowest pending code wins the single push slot
    always_comb begin
        grant     = '0;
        push      = 1'b0;
        push_code = '0;
        if (can_push) begin
            for (int i = 0; i < int'(NCODE); i++) begin
                if (pend_q[i] && !push) begin
                    push      = 1'b1;
                    grant[i]  = 1'b1;
                    push_code = 3'(i);
                end
            end
        end
    end

    // Pending flags; a new event hitting a still-held flag is a lost merge
    always_comb begin
        merge      = |(evt_set & pend_q & ~grant);
        pend_d     = (pend_q & ~grant) | evt_set;
        overflow_d = overflow;
        if (merge) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    // FIFO bookkeeping and next registered head
    always_comb begin
        rd_d      = pop ? rd_ptr + AW'(1) : rd_ptr;
        after_pop = pop ? count - CNTW'(1) : count;
        count_d   = after_pop + (push ? CNTW'(1) : CNTW'(0));
        head_d    = evt_code;
        if (after_pop == '0) begin
            if (push) begin
                head_d = push_code;
            end
        end else begin
            head_d = mem[rd_d];
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held      <= '0;
            pend_q    <= '0;
            overflow  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            evt_valid <= 1'b0;
            evt_code  <= '0;
            for (int i = 0; i < 2; i++) begin
                rpt_state_q[i] <= RPT_IDLE;
                cnt_q[i]       <= '0;
            end
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            held      <= {enter, right, left, up};
            pend_q    <= pend_d;
            overflow  <= overflow_d;
            rd_ptr    <= rd_d;
            count     <= count_d;
            evt_valid <= (count_d != '0);
            evt_code  <= head_d;
            for (int i = 0; i < 2; i++) begin
                rpt_state_q[i] <= rpt_state_d[i];
                cnt_q[i]       <= cnt_d[i];
            end
            if (push) begin
                mem[wr_ptr] <= push_code;
                wr_ptr      <= wr_ptr + AW'(1);
            end
        end
    end

endmodule

// File: tb/tb_key_event_gen.sv
// tb_key_event_gen: directed scenarios plus randomized key activity, checked
// every cycle against a queue-based behavioural model of the event generator.
module tb_key_event_gen;

    localparam int DELAY = 8;
    localparam int RATE  = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       up, left, right, enter;
    logic       evt_valid;
    logic [2:0] evt_code;
    logic       evt_ready;
    logic [3:0] held;
    logic       overflow;
    logic       ovf_clr;

    int checks   = 0;
    int failures = 0;

    key_event_gen #(
        .DELAY_CYC (DELAY),
        .RATE_CYC  (RATE),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .up       (up),
        .left     (left),
        .right    (right),
        .enter    (enter),
        .evt_valid(evt_valid),
        .evt_code (evt_code),
        .evt_ready(evt_ready),
        .held     (held),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    // Behavioural model: event queue, pending set, hold lengths
    int       q[$];
    int       log_q[$];
    bit [6:0] mpend;
    bit       movf;
    bit [3:0] mheld;
    int       len[2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            log_q.delete();
            mpend  = '0;
            movf   = 1'b0;
            mheld  = '0;
            len[0] = 0;
            len[1] = 0;
        end else begin
            bit [3:0] lv;
            bit [6:0] ev;
            bit       do_pop;
            bit       accept;
            bit       mrg;
            int       gnt;
            lv = {enter, right, left, up};
            ev = '0;
            for (int k = 0; k < 4; k++) ev[k] = lv[k] && !mheld[k];
            ev[6] = !lv[0] && mheld[0];
            // repeat when hold length reaches DELAY+1, then every RATE
            for (int d = 0; d < 2; d++) begin
                len[d] = lv[1+d] ? len[d] + 1 : 0;
                if (lv[1+d] && len[d] > DELAY && ((len[d] - 1 - DELAY) % RATE) == 0)
                    ev[4+d] = 1'b1;
            end
            do_pop = (q.size() != 0) && (evt_ready === 1'b1);
            accept = (q.size() < DEPTH) || do_pop;
            gnt = -1;
            if (accept) begin
                for (int k = 0; k < 7; k++) begin
                    if (gnt < 0 && mpend[k]) gnt = k;
                end
            end
            if (do_pop) log_q.push_back(q.pop_front());
            if (gnt >= 0) begin
                q.push_back(gnt);
                mpend[gnt] = 1'b0;
            end
            mrg = |(ev & mpend);
            mpend = mpend | ev;
            if (mrg) movf = 1'b1;
            else if (ovf_clr) movf = 1'b0;
            mheld = lv;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Popped-event history packed as nibbles, oldest first
    task automatic check_log(input string nm, input int n, input logic [31:0] exp);
        logic [31:0] w;
        w = '0;
        foreach (log_q[i]) w = (w << 4) | 32'(log_q[i] & 15);
        chk({nm, "_len"}, 32'(log_q.size()), 32'(n));
        chk(nm, w, exp);
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("evt_valid", 32'(evt_valid), 32'(q.size() != 0));
            if (q.size() != 0) chk("evt_code", 32'(evt_code), 32'(q[0]));
            chk("held", 32'(held), 32'(mheld));
            chk("overflow", 32'(overflow), 32'(movf));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; up = 0; left = 0; right = 0; enter = 0;
        evt_ready = 1'b1; ovf_clr = 1'b0;
        tick(2);
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_code", 32'(evt_code), 32'd0);
        chk("rst_held", 32'(held), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;
        tick(2);

        // Short left pulse: one press, visible two cycles after the rise
        log_q.delete();
        left = 1;
        tick(1);
        chk("s1_lat1", 32'(evt_valid), 32'd0);
        tick(1);
        chk("s1_lat2_valid", 32'(evt_valid), 32'd1);
        chk("s1_lat2_code", 32'(evt_code), 32'd1);
        tick(1);
        left = 0;
        tick(10);
        check_log("s1_log", 1, 32'h1);
        chk("s1_ovf", 32'(overflow), 32'd0);

        // Long right hold: press plus three repeats
        log_q.delete();
        right = 1;
        tick(20);
        right = 0;
        tick(10);
        check_log("s2_log", 4, 32'h2555);

        // Simultaneous presses then up release
        log_q.delete();
        up = 1; left = 1; enter = 1;
        tick(2);
        up = 0;
        tick(2);
        left = 0; enter = 0;
        tick(8);
        check_log("s3_log", 4, 32'h0136);

        // Stalled consumer: FIFO fills, rest wait pending, one merge
        log_q.delete();
        evt_ready = 0;
        up = 1; left = 1; right = 1; enter = 1;
        tick(3);
        up = 0;
        tick(1);
        up = 1;
        tick(1);
        up = 0;
        tick(5);
        left = 0; right = 0; enter = 0;
        chk("s4_valid", 32'(evt_valid), 32'd1);
        chk("s4_code", 32'(evt_code), 32'd0);
        chk("s4_ovf", 32'(overflow), 32'd1);
        tick(4);
        chk("s4_code_hold", 32'(evt_code), 32'd0);
        evt_ready = 1;
        tick(12);
        check_log("s4_log", 8, 32'h01230456);

        // Overflow clear, then clear colliding with a merge
        ovf_clr = 1;
        tick(1);
        ovf_clr = 0;
        chk("s5_clr", 32'(overflow), 32'd0);
        evt_ready = 0;
        for (int i = 0; i < 6; i++) begin
            up = ~up;
            tick(1);
        end
        up = 1; ovf_clr = 1;
        tick(1);
        ovf_clr = 0;
        chk("s5_set_beats_clr", 32'(overflow), 32'd1);
        up = 0;
        evt_ready = 1;
        tick(12);

        // Async reset with two queued events and left repeating
        log_q.delete();
        evt_ready = 0;
        left = 1;
        tick(11);
        chk("s6_pre_valid", 32'(evt_valid), 32'd1);
        chk("s6_pre_ovf", 32'(overflow), 32'd1);
        #2 rst = 1;
        #1;
        chk("s6_rst_valid", 32'(evt_valid), 32'd0);
        chk("s6_rst_ovf", 32'(overflow), 32'd0);
        chk("s6_rst_held", 32'(held), 32'd0);
        @(negedge clk);
        #2 rst = 0;
        evt_ready = 1;
        tick(4);
        check_log("s6_log", 1, 32'h1);
        left = 0;
        tick(4);

        // Randomized key activity, consumer stalls and clears
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(15) == 0) up = ~up;
            if ($urandom_range(15) == 0) left = ~left;
            if ($urandom_range(15) == 0) right = ~right;
            if ($urandom_range(15) == 0) enter = ~enter;
            evt_ready = ($urandom_range(3) != 0);
            ovf_clr = ($urandom_range(31) == 0);
            tick(1);
        end
        up = 0; left = 0; right = 0; enter = 0; ovf_clr = 0; evt_ready = 1;
        tick(20);
        chk("final_drained", 32'(evt_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
